comparator32_arbiter: RTL and testbench
=======================================

# comparator32_arbiter

Round-robin arbiter and sequencer that shares a single `comparator32` instance among `NUM_REQ` requesters. It accepts one compare request at a time, captures the operands, drives the shared comparator and returns a registered gt/lt/eq result with a one-hot done pulse to the granted requester. The block sits between multiple compare-issuing clients and the one 32-bit comparator datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset; **asynchronous, active-low**.
- `req_i`  in  `NUM_REQ`  per-requester request valid.
- `a_i`  in  `NUM_REQ*32`  operand A; requester k is at bits [32k+31:32k].
- `b_i`  in  `NUM_REQ*32`  operand B; same packing as `a_i`.
- `gnt_o`  out  `NUM_REQ`  one-hot accept pulse; operands are captured at the end of this cycle.
- `done_o`  out  `NUM_REQ`  one-hot, one-cycle result-valid pulse to the owner.
- `gt_o`, `lt_o`, `eq_o`  out  1 each  registered result; the compare is unsigned.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, CMP, STAGE (present only with the macro), DONE.
- **IDLE:**
  - If any `req_i` bit is set, `gnt_o` combinationally selects the first set bit, searching upward from `ptr_q` with wrap.
  - At the edge, the block captures `a_q`/`b_q`/`owner_q` from the granted slice, then moves to CMP.
  - If no request is set, it stays in IDLE and `gnt_o` is 0.
- **CMP:** the comparator sees `a_q`/`b_q`. At the edge, its outputs are registered into `gt_o`/`lt_o`/`eq_o`, then the FSM moves to DONE (or to STAGE when the macro is defined).
- **DONE:**
  - `done_o` equals the one-hot `owner_q`.
  - At the edge, `ptr_q` becomes `(owner_q+1) mod NUM_REQ` and the FSM returns to IDLE.
- **Result hold:** `gt_o`/`lt_o`/`eq_o` hold their value until the next CMP-stage update. They are only meaningful while `done_o` is nonzero.
- **Exactly one result bit:** exactly one of gt/lt/eq is set after the first completed compare.
- **Requester protocol:**
  - A requester holds `req_i` and its operands stable until it sees its `gnt_o` bit.
  - Operands may change in the cycle after the grant.
  - If `req_i` is still high once the FSM is back in IDLE, it counts as a new request.
- **Non-requesters:** `req_i` bits that are low are never granted. Operand slices of requesters that are not granted are ignored.
- **Simultaneous requests:** they are resolved purely by `ptr_q` priority, which gives fair rotation. No requester waits more than `NUM_REQ` transactions.
- **Reset:**
  - Values after reset: state=IDLE, `ptr_q`=0, `gnt_o`=0, `done_o`=0, `gt_o`=`lt_o`=`eq_o`=0, `busy_o`=0.
  - If reset is asserted mid-transaction, the transaction is abandoned: no `done_o` is produced and `ptr_q` returns to 0.

## Timing
- **Latency:** a grant in cycle T gives `done_o` in cycle T+2. With `CMP_ARB_PIPE_EN`, it is T+3.
- **Throughput:** one compare per 3 cycles (4 cycles with the macro). The earliest next grant is the cycle after DONE.
- **Output types:** `gnt_o` is Mealy (IDLE and `req_i`). All other outputs are registered.
- **`busy_o`:** high from T+1 through the DONE cycle.

## Configuration
- **`CMP_ARB_PIPE_EN` defined:**
  - A register stage is inserted on the comparator outputs.
  - CMP registers the raw gt/lt/eq into `res_q` and moves to STAGE.
  - STAGE copies `res_q` to the outputs and moves to DONE.
  - Latency becomes 3.
- **Not defined:** STAGE does not exist and latency is 2.

## Structure
- **Package `cmp_arb_pkg`:**
  - `DATA_W = 32`
  - the state enum typedef `cmp_arb_state_e`
  - a round-robin pick function that takes (req, ptr) and returns a one-hot vector.
- **Sub-module:** a single `comparator32` instance, connected as `.a_i(a_q)`, `.b_i(b_q)`, gt/lt/eq. No other sub-modules are used.

## Test plan
- **Reset:** hold `rst_ni`=0 with `req_i`=4'b1111 → all outputs are 0. After release, the first grant is 4'b0001.
- **Single request, A greater:** `req_i`=4'b0001, a0=0x7777_7777, b0=0x5555_5555 → `gnt_o`=0001 at T, `done_o`=0001 at T+2, gt=1, lt=0, eq=0.
- **Unsigned boundary:** `req_i`=4'b0100, a2=0xFFFF_FFFE, b2=0xFFFF_FFFF → `done_o`=0100, lt=1. Then a2=b2=0xFFFF_FFFF → eq=1.
- **Full contention:** `req_i`=4'b1111 held high → grants rotate 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart. Each `done_o` matches its grant.
- **Pointer wrap:** after a grant to requester 2, `req_i`=4'b0101 → the next grant is 0001, because the search order is 3, 0, 1, 2.
- **Reset mid-operation:** pulse `rst_ni` low during CMP → no `done_o` is produced and `busy_o`=0. With `CMP_ARB_PIPE_EN`, rerun the single-request case → `done_o` arrives at T+3.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// Shared types and helpers for comparator32_arbiter.
// Optional CMP_ARB_PIPE_EN adds the STAGE state for the registered comparator output.
package cmp_arb_pkg;

   localparam int DATA_W  = 32;
   localparam int MAX_REQ = 16;
   localparam int IDX_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMP   = 2'd1,
`ifdef CMP_ARB_PIPE_EN
      ST_STAGE = 2'd2,
`endif
      ST_DONE  = 2'd3
   } cmp_arb_state_e;

   // Round-robin pick: first set request at or above ptr, wrapping modulo n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [IDX_W-1:0]   ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] gnt;
      logic [IDX_W-1:0]   idx;
      logic               found;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % n);
         if (i < n && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/comparator32.sv
// Combinational unsigned 32-bit magnitude comparator.
module comparator32
   import cmp_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              gt_o,
   output logic              lt_o,
   output logic              eq_o
);

   assign gt_o = (a_i >  b_i);
   assign lt_o = (a_i <  b_i);
   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator32_arbiter.sv
// Round-robin arbiter sharing one comparator32 among NUM_REQ requesters.
// Define CMP_ARB_PIPE_EN to register the comparator outputs (latency 3 instead of 2).
module comparator32_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] a_i,
   input  logic [NUM_REQ*DATA_W-1:0] b_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      gt_o,
   output logic                      lt_o,
   output logic                      eq_o,
   output logic                      busy_o
);

   localparam int PTR_W = $clog2(NUM_REQ);

   cmp_arb_state_e     state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   owner_q;
   logic [PTR_W-1:0]   gnt_idx;
   logic [MAX_REQ-1:0] pick;
   logic [DATA_W-1:0]  a_q, b_q;
   logic               cmp_gt, cmp_lt, cmp_eq;
   logic               gt_q, lt_q, eq_q;
   logic               capture;
`ifdef CMP_ARB_PIPE_EN
   logic [2:0]         res_q;
`endif

   assign pick    = rr_pick(MAX_REQ'(req_i), IDX_W'(ptr_q), NUM_REQ);
   assign capture = (state_q == ST_IDLE) && (|req_i);

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (pick[k]) gnt_idx = PTR_W'(k);
      end
   end

   // Gated by reset so no grant is offered while the block is held in reset.
   assign gnt_o  = (state_q == ST_IDLE && rst_ni) ? pick[NUM_REQ-1:0] : '0;
   assign busy_o = (state_q != ST_IDLE);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      done_o = '0;
      if (state_q == ST_DONE) done_o[owner_q] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: if (|req_i) state_d = ST_CMP;
`ifdef CMP_ARB_PIPE_EN
         ST_CMP:   state_d = ST_STAGE;
         ST_STAGE: state_d = ST_DONE;
`else
         ST_CMP:   state_d = ST_DONE;
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   comparator32 u_cmp (
      .a_i  (a_q),
      .b_i  (b_q),
      .gt_o (cmp_gt),
      .lt_o (cmp_lt),
      .eq_o (cmp_eq)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
`ifdef CMP_ARB_PIPE_EN
         res_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (capture) owner_q <= gnt_idx;
`ifdef CMP_ARB_PIPE_EN
         if (state_q == ST_CMP)   res_q <= {cmp_gt, cmp_lt, cmp_eq};
         if (state_q == ST_STAGE) {gt_q, lt_q, eq_q} <= res_q;
`else
         if (state_q == ST_CMP)   {gt_q, lt_q, eq_q} <= {cmp_gt, cmp_lt, cmp_eq};
`endif
      end
   end

   // NOTE: operand registers are pure datapath, always written before use, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         a_q <= a_i[gnt_idx*DATA_W +: DATA_W];
         b_q <= b_i[gnt_idx*DATA_W +: DATA_W];
      end
   end

   assign gt_o = gt_q;
   assign lt_o = lt_q;
   assign eq_o = eq_q;

endmodule

// File: tb/tb_comparator32_arbiter.sv
// Scoreboard bench for comparator32_arbiter: the driver pushes expected results on each grant,
// and the monitor pops and compares them whenever done_o fires.
module tb_comparator32_arbiter;

`ifdef CMP_ARB_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int SPACING = LAT + 1;

   typedef struct {
      logic [3:0] done;
      logic [2:0] res;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [3:0]  req;
   logic [31:0] a_v [4];
   logic [31:0] b_v [4];
   logic [127:0] a_bus, b_bus;
   logic [3:0]  gnt_o, done_o;
   logic        gt_o, lt_o, eq_o, busy_o;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];

   assign a_bus = {a_v[3], a_v[2], a_v[1], a_v[0]};
   assign b_bus = {b_v[3], b_v[2], b_v[1], b_v[0]};

   comparator32_arbiter #(.NUM_REQ(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .req_i  (req),
      .a_i    (a_bus),
      .b_i    (b_bus),
      .gnt_o  (gnt_o),
      .done_o (done_o),
      .gt_o   (gt_o),
      .lt_o   (lt_o),
      .eq_o   (eq_o),
      .busy_o (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge with inputs already set; returns at the negedge after the grant.
   task automatic issue(input logic [3:0] exp_gnt, input logic [2:0] exp_res,
                        input string name, output int gcyc);
      int n = 0;
      #1;
      while (gnt_o == 4'b0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      gcyc = cyc;
      if (gnt_o == 4'b0) begin
         checks++;
         failures++;
         $display("FAIL %s: no grant within 20 cycles, expected %b", name, exp_gnt);
      end else begin
         check(name, {28'b0, gnt_o}, {28'b0, exp_gnt});
         sb.push_back('{done: exp_gnt, res: exp_res, cyc: cyc});
      end
      @(negedge clk);
   endtask

   // Monitor: compare every done_o pulse against the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (done_o != 4'b0) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got %b with empty scoreboard", done_o);
            end else begin
               e = sb.pop_front();
               check("done_owner", {28'b0, done_o}, {28'b0, e.done});
               check("result_gt_lt_eq", {29'b0, gt_o, lt_o, eq_o}, {29'b0, e.res});
               check("latency", cyc - e.cyc, LAT);
               check("busy_in_done", {31'b0, busy_o}, 32'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, prev;
      logic [3:0] rr_exp [5];
      logic [2:0] rr_res [5];
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      // {gt,lt,eq}: r0 1<2 lt, r1 0x80000000>0x7FFFFFFF gt, r2 equal, r3 0<max lt
      rr_res = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b010};

      rst_ni = 1'b0;
      req    = 4'b1111;
      a_v[0] = 32'd1;          b_v[0] = 32'd2;
      a_v[1] = 32'h8000_0000;  b_v[1] = 32'h7FFF_FFFF;
      a_v[2] = 32'h1234_5678;  b_v[2] = 32'h1234_5678;
      a_v[3] = 32'h0;          b_v[3] = 32'hFFFF_FFFF;

      repeat (3) @(negedge clk);
      #1;
      check("rst_gnt",  {28'b0, gnt_o},  32'd0);
      check("rst_done", {28'b0, done_o}, 32'd0);
      check("rst_res",  {29'b0, gt_o, lt_o, eq_o}, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Full contention: rotation starting at requester 0 after reset.
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         issue(rr_exp[i], rr_res[i], $sformatf("rr_grant%0d", i), g);
         if (i > 0) check($sformatf("rr_spacing%0d", i), g - prev, SPACING);
         prev = g;
      end

      // Single request, A greater (ptr now 1, search wraps to 0).
      req = 4'b0001;
      a_v[0] = 32'h7777_7777;  b_v[0] = 32'h5555_5555;
      issue(4'b0001, 3'b100, "single_gt", g);

      // Unsigned boundary on requester 2.
      req = 4'b0100;
      a_v[2] = 32'hFFFF_FFFE;  b_v[2] = 32'hFFFF_FFFF;
      issue(4'b0100, 3'b010, "boundary_lt", g);
      a_v[2] = 32'hFFFF_FFFF;
      issue(4'b0100, 3'b001, "boundary_eq", g);

      // Pointer wrap: ptr=3, search 3,0,1,2 picks requester 0.
      req = 4'b0101;
      issue(4'b0001, 3'b100, "wrap_grant", g);
      req = 4'b0100;
      issue(4'b0100, 3'b001, "wrap_followup", g);

      // No requests: no grant, block goes idle.
      req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("idle_gnt%0d", i), {28'b0, gnt_o}, 32'd0);
         @(negedge clk);
      end
      #1;
      check("idle_busy", {31'b0, busy_o}, 32'd0);

      // Reset mid-operation: transaction abandoned, pointer back to 0.
      req = 4'b0010;
      a_v[1] = 32'd3;  b_v[1] = 32'd3;
      issue(4'b0010, 3'b001, "midrst_grant", g);
      req    = 4'b0000;
      rst_ni = 1'b0;
      if (sb.size() > 0) void'(sb.pop_back());
      #1;
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      check("midrst_done", {28'b0, done_o}, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("post_rst_busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk);

      // ptr reset to 0: search 0,1,2,3 over 1010 picks requester 1.
      req = 4'b1010;
      a_v[1] = 32'd9;  b_v[1] = 32'd4;
      issue(4'b0010, 3'b100, "post_rst_ptr", g);
      req = 4'b0000;

      for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d results never arrived", sb.size());
      end
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
